// File: rtl/complete_retire_pkg.sv
// ---------------------------------------------------------------------------
// complete_retire_pkg
// Shared types and sizing constants for the reorder-buffer complete/retire
// block.
//   word                  : 32-bit datapath word
//   rob_tag_t             : reorder-buffer entry tag
//   complete_stage_struct : one functional-unit completion record
// ---------------------------------------------------------------------------
package complete_retire_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int RETIRE_WIDTH = 2;
    localparam int TAG_W        = $clog2(ROB_DEPTH);

    typedef logic [31:0]      word;
    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        rob_tag_t   ROBNumber;
        logic       RegWrite;
        logic       MemWrite;
        logic       ready;
        logic [1:0] fu;
        word        FU_Result;
    } complete_stage_struct;

endpackage

// File: rtl/complete_retire_retire_select.sv
// ---------------------------------------------------------------------------
// retire_select
// Combinational retire window: decides which of the two oldest entries
// retire this cycle.
//   i_head   : oldest entry index
//   i_valid  : per-entry allocated bits
//   i_done   : per-entry completed bits
//   i_store  : per-entry store flags
//   o_ret0   : entry at head retires
//   o_ret1   : entry at head+1 retires (only together with o_ret0)
//   o_idx1   : index of head+1 (wraps)
// ---------------------------------------------------------------------------
module retire_select
    import complete_retire_pkg::*;
#(
    parameter int  ROB_DEPTH    = complete_retire_pkg::ROB_DEPTH,
    parameter int  RETIRE_WIDTH = complete_retire_pkg::RETIRE_WIDTH,
    localparam int TW           = $clog2(ROB_DEPTH)
)(
    input  logic [TW-1:0]        i_head,
    input  logic [ROB_DEPTH-1:0] i_valid,
    input  logic [ROB_DEPTH-1:0] i_done,
    input  logic [ROB_DEPTH-1:0] i_store,
    output logic                 o_ret0,
    output logic                 o_ret1,
    output logic [TW-1:0]        o_idx1
);

    always_comb begin
        o_idx1 = i_head + TW'(1);
        o_ret0 = i_valid[i_head] & i_done[i_head];
        // Only one memory port: a second store waits for the next cycle.
        o_ret1 = (RETIRE_WIDTH > 1) & o_ret0
               & i_valid[o_idx1] & i_done[o_idx1]
               & ~(i_store[i_head] & i_store[o_idx1]);
    end

endmodule

// File: rtl/complete_retire.sv
// ---------------------------------------------------------------------------
// complete_retire
// Reorder buffer: allocates entries in program order, accepts up to three
// functional-unit completions per cycle, and retires up to two completed
// entries in order, producing registered register-file and store writes.
//   i_clk / i_rst          : clock, asynchronous active-high reset
//   i_alloc_*              : tail allocation request and payload
//   o_alloc_ready/o_alloc_tag : allocation handshake and assigned tag
//   i_complete_result[0:2] : per-FU completion records
//   o_rf_we/waddr/wdata    : per-slot register writes (registered)
//   o_mem_we/addr/wdata    : committed store (registered)
//   o_retire_count         : entries retired on the previous edge
//   o_empty / o_full       : occupancy flags
// ---------------------------------------------------------------------------
module complete_retire
    import complete_retire_pkg::*;
#(
    parameter int  ROB_DEPTH    = complete_retire_pkg::ROB_DEPTH,
    parameter int  RETIRE_WIDTH = complete_retire_pkg::RETIRE_WIDTH,
    localparam int TW           = $clog2(ROB_DEPTH)
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alloc_valid,
    input  logic [4:0]           i_alloc_rd,
    input  logic                 i_alloc_regwrite,
    input  logic                 i_alloc_memwrite,
    input  word                  i_alloc_store_data,
    output logic                 o_alloc_ready,
    output logic [TW-1:0]        o_alloc_tag,
    input  complete_stage_struct i_complete_result [0:2],
    output logic                 o_rf_we    [0:1],
    output logic [4:0]           o_rf_waddr [0:1],
    output word                  o_rf_wdata [0:1],
    output logic                 o_mem_we,
    output word                  o_mem_addr,
    output word                  o_mem_wdata,
    output logic [1:0]           o_retire_count,
    output logic                 o_empty,
    output logic                 o_full
);

    localparam logic [TW:0] CNT_FULL = (TW+1)'(ROB_DEPTH);

    logic [TW-1:0]        r_head;
    logic [TW-1:0]        r_tail;
    logic [TW:0]          r_count;
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_store;
    logic [ROB_DEPTH-1:0] r_regw;
    logic [4:0]           r_rd     [ROB_DEPTH];
    word                  r_sdata  [ROB_DEPTH];
    word                  r_result [ROB_DEPTH];

    logic          w_alloc;
    logic [2:0]    w_accept;
    logic          w_ret0;
    logic          w_ret1;
    logic [TW-1:0] w_idx1;
    logic [1:0]    w_nret;
    logic          w_rf_we0;
    logic          w_rf_we1;
    logic          w_st0;
    logic          w_st1;

    assign o_alloc_ready = (r_count != CNT_FULL);
    assign o_alloc_tag   = r_tail;
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CNT_FULL);
    assign w_alloc       = i_alloc_valid & o_alloc_ready;

    retire_select #(
        .ROB_DEPTH    (ROB_DEPTH),
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) u_retire_select (
        .i_head  (r_head),
        .i_valid (r_valid),
        .i_done  (r_done),
        .i_store (r_store),
        .o_ret0  (w_ret0),
        .o_ret1  (w_ret1),
        .o_idx1  (w_idx1)
    );

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_accept[s] = i_complete_result[s].ready
                        & r_valid[i_complete_result[s].ROBNumber];
        end
        w_nret   = {1'b0, w_ret0} + {1'b0, w_ret1};
        w_rf_we0 = w_ret0 & r_regw[r_head] & (r_rd[r_head] != 5'd0);
        w_rf_we1 = w_ret1 & r_regw[w_idx1] & (r_rd[w_idx1] != 5'd0);
        w_st0    = w_ret0 & r_store[r_head];
        w_st1    = w_ret1 & r_store[w_idx1];
    end

    // Pointers and per-entry status. Later assignments win: a retiring entry
    // is cleared even if a stale completion names it in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (w_accept[s]) r_done[i_complete_result[s].ROBNumber] <= 1'b1;
            end
            if (w_ret0) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_ret1) begin
                r_valid[w_idx1] <= 1'b0;
                r_done[w_idx1]  <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
            r_head  <= r_head + TW'(w_nret);
            r_tail  <= r_tail + TW'(w_alloc);
            r_count <= r_count + (TW+1)'(w_alloc) - (TW+1)'(w_nret);
        end
    end

    // Entry payload; only meaningful while the valid bit is set, so no reset.
    // Slot loop order makes the highest slot win on a duplicate tag.
    always_ff @(posedge i_clk) begin
        if (w_alloc) begin
            r_rd[r_tail]    <= i_alloc_rd;
            r_regw[r_tail]  <= i_alloc_regwrite;
            r_store[r_tail] <= i_alloc_memwrite;
            if (i_alloc_memwrite) r_sdata[r_tail] <= i_alloc_store_data;
        end
        for (int s = 0; s < 3; s++) begin
            if (w_accept[s]) r_result[i_complete_result[s].ROBNumber] <= i_complete_result[s].FU_Result;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_retire_count <= '0;
            o_rf_we[0]     <= 1'b0;
            o_rf_we[1]     <= 1'b0;
            o_rf_waddr[0]  <= '0;
            o_rf_waddr[1]  <= '0;
            o_rf_wdata[0]  <= '0;
            o_rf_wdata[1]  <= '0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
        end else begin
            o_retire_count <= w_nret;
            o_rf_we[0]     <= w_rf_we0;
            o_rf_we[1]     <= w_rf_we1;
            o_mem_we       <= w_st0 | w_st1;
            if (w_rf_we0) begin
                o_rf_waddr[0] <= r_rd[r_head];
                o_rf_wdata[0] <= r_result[r_head];
            end
            if (w_rf_we1) begin
                o_rf_waddr[1] <= r_rd[w_idx1];
                o_rf_wdata[1] <= r_result[w_idx1];
            end
            if (w_st0) begin
                o_mem_addr  <= r_result[r_head];
                o_mem_wdata <= r_sdata[r_head];
            end else if (w_st1) begin
                o_mem_addr  <= r_result[w_idx1];
                o_mem_wdata <= r_sdata[w_idx1];
            end
        end
    end

endmodule

// File: tb/tb_complete_retire.sv
module tb_complete_retire;
    import complete_retire_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_alloc_valid;
    logic [4:0]           i_alloc_rd;
    logic                 i_alloc_regwrite;
    logic                 i_alloc_memwrite;
    word                  i_alloc_store_data;
    logic                 o_alloc_ready;
    logic [3:0]           o_alloc_tag;
    complete_stage_struct cr [0:2];
    logic                 o_rf_we    [0:1];
    logic [4:0]           o_rf_waddr [0:1];
    word                  o_rf_wdata [0:1];
    logic                 o_mem_we;
    word                  o_mem_addr;
    word                  o_mem_wdata;
    logic [1:0]           o_retire_count;
    logic                 o_empty;
    logic                 o_full;

    complete_retire #(.ROB_DEPTH(16), .RETIRE_WIDTH(2)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_alloc_valid      (i_alloc_valid),
        .i_alloc_rd         (i_alloc_rd),
        .i_alloc_regwrite   (i_alloc_regwrite),
        .i_alloc_memwrite   (i_alloc_memwrite),
        .i_alloc_store_data (i_alloc_store_data),
        .o_alloc_ready      (o_alloc_ready),
        .o_alloc_tag        (o_alloc_tag),
        .i_complete_result  (cr),
        .o_rf_we            (o_rf_we),
        .o_rf_waddr         (o_rf_waddr),
        .o_rf_wdata         (o_rf_wdata),
        .o_mem_we           (o_mem_we),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wdata        (o_mem_wdata),
        .o_retire_count     (o_retire_count),
        .o_empty            (o_empty),
        .o_full             (o_full)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: the ROB as an in-order queue of instructions.
    typedef struct {
        int         tag;
        logic [4:0] rd;
        bit         regw;
        bit         memw;
        word        sdata;
        bit         done;
        word        result;
    } ent_t;

    ent_t       mq[$];
    int         m_tail;
    bit         e_rfwe  [2];
    logic [4:0] e_waddr [2];
    word        e_wdata [2];
    bit         e_mwe;
    word        e_maddr;
    word        e_mdata;
    int         e_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       x_ready;

    typedef struct {
        bit av; logic [4:0] rd; bit rw; bit mw; word sd;
        bit c0v; int c0t; word c0r; bit c1v; int c1t; word c1r;
        int x_cnt; bit x_mwe; word x_maddr; word x_mdata; int x_tag;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_alloc_valid      = 1'b0;
        i_alloc_rd         = '0;
        i_alloc_regwrite   = 1'b0;
        i_alloc_memwrite   = 1'b0;
        i_alloc_store_data = '0;
        for (int s = 0; s < 3; s++) cr[s] = '0;
    endtask

    task automatic set_alloc(input logic [4:0] rd, input bit rw, input bit mw, input word sd);
        i_alloc_valid      = 1'b1;
        i_alloc_rd         = rd;
        i_alloc_regwrite   = rw;
        i_alloc_memwrite   = mw;
        i_alloc_store_data = sd;
    endtask

    task automatic set_comp(input int slot, input int tag, input word res);
        cr[slot].ROBNumber = rob_tag_t'(tag);
        cr[slot].RegWrite  = 1'b0;
        cr[slot].MemWrite  = 1'b0;
        cr[slot].ready     = 1'b1;
        cr[slot].fu        = 2'(slot);
        cr[slot].FU_Result = res;
    endtask

    // One clock: predict from the pre-edge model state, advance, compare.
    task automatic tick();
        int   n;
        bit   alloc_ok;
        ent_t e;
        n = 0;
        e_rfwe[0] = 0; e_rfwe[1] = 0; e_mwe = 0;
        if (mq.size() > 0 && mq[0].done) n = 1;
        if (n == 1 && mq.size() > 1 && mq[1].done && !(mq[0].memw && mq[1].memw)) n = 2;
        for (int s = 0; s < n; s++) begin
            if (mq[s].regw && mq[s].rd != 0) begin
                e_rfwe[s]  = 1;
                e_waddr[s] = mq[s].rd;
                e_wdata[s] = mq[s].result;
            end
            if (mq[s].memw) begin
                e_mwe   = 1;
                e_maddr = mq[s].result;
                e_mdata = mq[s].sdata;
            end
        end
        e_cnt = n;
        for (int s = 0; s < 3; s++) begin
            if (cr[s].ready === 1'b1) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].tag == int'(cr[s].ROBNumber)) begin
                        mq[j].done   = 1;
                        mq[j].result = cr[s].FU_Result;
                    end
                end
            end
        end
        alloc_ok = (i_alloc_valid === 1'b1) && (mq.size() < 16);
        for (int k = 0; k < n; k++) mq.delete(0);
        if (alloc_ok) begin
            e.tag = m_tail; e.rd = i_alloc_rd; e.regw = i_alloc_regwrite;
            e.memw = i_alloc_memwrite; e.sdata = i_alloc_store_data;
            e.done = 0; e.result = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
        @(posedge i_clk);
        #1;
        chk("retire_count", 32'(o_retire_count), 32'(e_cnt));
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rf_we[%0d]", s), 32'(o_rf_we[s]), 32'(e_rfwe[s]));
            if (e_rfwe[s]) begin
                chk($sformatf("rf_waddr[%0d]", s), 32'(o_rf_waddr[s]), 32'(e_waddr[s]));
                chk($sformatf("rf_wdata[%0d]", s), o_rf_wdata[s], e_wdata[s]);
            end
        end
        chk("mem_we", 32'(o_mem_we), 32'(e_mwe));
        if (e_mwe) begin
            chk("mem_addr", o_mem_addr, e_maddr);
            chk("mem_wdata", o_mem_wdata, e_mdata);
        end
        chk("empty", 32'(o_empty), 32'(mq.size() == 0));
        chk("full", 32'(o_full), 32'(mq.size() == 16));
        chk("alloc_ready", 32'(o_alloc_ready), 32'(mq.size() < 16));
        chk("alloc_tag", 32'(o_alloc_tag), 32'(m_tail));
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        mq.delete();
        m_tail = 0;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_alloc_ready", 32'(o_alloc_ready), 32'd1);
        chk("rst_alloc_tag", 32'(o_alloc_tag), 32'd0);
        chk("rst_retire_count", 32'(o_retire_count), 32'd0);
        chk("rst_rf_we0", 32'(o_rf_we[0]), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        i_rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic xp;
        xp = 1'bx;
        // A two-state simulator folds X to 0 or 1; never let it become a real "ready".
        x_ready = (xp === 1'b1) ? 1'b0 : xp;
        m_tail  = 0;
        i_rst   = 1'b0;
        clear_inputs();
        #3;
        do_reset();

        // In-order retire, out-of-order completion, store serialisation.
        //         av rd  rw mw sd      c0v c0t c0r       c1v c1t c1r       cnt mwe maddr     mdata  tag
        vt.push_back('{1, 1, 1, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  1});
        vt.push_back('{1, 2, 1, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  2});
        vt.push_back('{1, 3, 1, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  3});
        vt.push_back('{0, 0, 0, 0, 32'h0,  1, 1, 32'h11,   0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  3});
        vt.push_back('{0, 0, 0, 0, 32'h0,  1, 0, 32'h10,   0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  3});
        vt.push_back('{0, 0, 0, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    2, 0, 32'h0,    32'h0,  3});
        vt.push_back('{0, 0, 0, 0, 32'h0,  1, 2, 32'h12,   0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  3});
        vt.push_back('{1, 0, 0, 1, 32'hA0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 32'h0,    32'h0,  4});
        vt.push_back('{1, 0, 0, 1, 32'hB0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  5});
        vt.push_back('{0, 0, 0, 0, 32'h0,  1, 3, 32'h1000, 1, 4, 32'h2000, 0, 0, 32'h0,    32'h0,  5});
        vt.push_back('{0, 0, 0, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 32'h1000, 32'hA0, 5});
        vt.push_back('{0, 0, 0, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 32'h2000, 32'hB0, 5});
        vt.push_back('{0, 0, 0, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    32'h0,  5});
        for (int i = 0; i < vt.size(); i++) begin
            clear_inputs();
            if (vt[i].av) set_alloc(vt[i].rd, vt[i].rw, vt[i].mw, vt[i].sd);
            if (vt[i].c0v) set_comp(0, vt[i].c0t, vt[i].c0r);
            if (vt[i].c1v) set_comp(1, vt[i].c1t, vt[i].c1r);
            tick();
            chk($sformatf("vec%0d_cnt", i), 32'(o_retire_count), 32'(vt[i].x_cnt));
            chk($sformatf("vec%0d_mem_we", i), 32'(o_mem_we), 32'(vt[i].x_mwe));
            if (vt[i].x_mwe) begin
                chk($sformatf("vec%0d_mem_addr", i), o_mem_addr, vt[i].x_maddr);
                chk($sformatf("vec%0d_mem_wdata", i), o_mem_wdata, vt[i].x_mdata);
            end
            chk($sformatf("vec%0d_tag", i), 32'(o_alloc_tag), 32'(vt[i].x_tag));
        end

        // Full buffer: 17th allocation dropped, also when a retire coincides.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            clear_inputs();
            set_alloc(5'(i + 1), 1, 0, 32'h0);
            tick();
        end
        chk("full_set", 32'(o_full), 32'd1);
        chk("full_not_ready", 32'(o_alloc_ready), 32'd0);
        tick();
        chk("full_drop_tag", 32'(o_alloc_tag), 32'd0);
        chk("full_still", 32'(o_full), 32'd1);
        set_comp(0, 0, 32'h55);
        tick();
        cr[0] = '0;
        tick();
        chk("full_retire_ready", 32'(o_alloc_ready), 32'd1);
        chk("full_retire_notfull", 32'(o_full), 32'd0);
        chk("full_retire_drop_tag", 32'(o_alloc_tag), 32'd0);
        tick();
        chk("full_realloc_tag", 32'(o_alloc_tag), 32'd1);

        // Completion with ready unknown must be ignored.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            set_alloc(5'(i + 1), 1, 0, 32'h0);
            tick();
        end
        clear_inputs();
        set_comp(0, 3, 32'h33);
        cr[0].ready = x_ready;
        tick();
        clear_inputs();
        tick();
        tick();
        chk("xready_no_retire", 32'(o_retire_count), 32'd0);
        set_comp(0, 0, 32'h30);
        set_comp(1, 1, 32'h31);
        set_comp(2, 2, 32'h32);
        tick();
        clear_inputs();
        repeat (4) tick();
        chk("xready_tag3_pending", 32'(o_empty), 32'd0);
        chk("xready_tag3_no_retire", 32'(o_retire_count), 32'd0);

        // Wrap: head at 15, entries 15 and 0 retire together.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            clear_inputs();
            set_alloc(5'(i + 1), 1, 0, 32'h0);
            tick();
        end
        for (int g = 0; g < 5; g++) begin
            clear_inputs();
            for (int s = 0; s < 3; s++) set_comp(s, g * 3 + s, 32'(100 + g * 3 + s));
            tick();
        end
        clear_inputs();
        repeat (10) tick();
        chk("wrap_empty_pre", 32'(o_empty), 32'd1);
        chk("wrap_tail15", 32'(o_alloc_tag), 32'd15);
        set_alloc(5'd20, 1, 0, 32'h0);
        tick();
        set_alloc(5'd21, 1, 0, 32'h0);
        tick();
        clear_inputs();
        set_comp(0, 15, 32'hF15);
        set_comp(1, 0, 32'hF00);
        tick();
        clear_inputs();
        tick();
        chk("wrap_retire2", 32'(o_retire_count), 32'd2);
        chk("wrap_empty_post", 32'(o_empty), 32'd1);
        chk("wrap_tail1", 32'(o_alloc_tag), 32'd1);

        // Asynchronous reset with five entries pending.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            set_alloc(5'(i + 5), 1, 0, 32'h0);
            tick();
        end
        clear_inputs();
        set_comp(0, 0, 32'h500);
        tick();
        clear_inputs();
        tick();
        set_comp(0, 1, 32'h501);
        set_comp(1, 2, 32'h502);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_rf_we0", 32'(o_rf_we[0]), 32'd0);
        chk("arst_retire_count", 32'(o_retire_count), 32'd0);
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_full", 32'(o_full), 32'd0);
        chk("arst_alloc_ready", 32'(o_alloc_ready), 32'd1);
        chk("arst_alloc_tag", 32'(o_alloc_tag), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        clear_inputs();
        i_rst = 1'b0;
        mq.delete();
        m_tail = 0;
        set_alloc(5'd7, 1, 0, 32'h0);
        tick();
        chk("arst_first_tag_next", 32'(o_alloc_tag), 32'd1);
        clear_inputs();
        set_comp(0, 0, 32'h77);
        tick();
        clear_inputs();
        tick();
        chk("arst_retire_cnt", 32'(o_retire_count), 32'd1);
        chk("arst_retire_waddr", 32'(o_rf_waddr[0]), 32'd7);
        chk("arst_retire_wdata", o_rf_wdata[0], 32'h77);

        // Randomised traffic against the queue model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            clear_inputs();
            if ($urandom_range(0, 9) < ((c < 1500) ? 8 : 4))
                set_alloc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), $urandom);
            for (int s = 0; s < 3; s++) begin
                r = $urandom_range(0, 9);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    cr[s].ROBNumber = rob_tag_t'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    cr[s].ROBNumber = rob_tag_t'($urandom_range(0, 15));
                cr[s].ready     = (r < 4);
                if (r == 4) cr[s].ready = x_ready;
                cr[s].fu        = 2'(s);
                cr[s].FU_Result = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/complete_retire.md
COMPLETE_RETIRE -- requirements
Module: complete_retire

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of reorder-buffer entries; power of two.
REQ-002 Parameter RETIRE_WIDTH, default 2, maximum entries retired per cycle.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_alloc_valid  input  1  request to allocate one tail entry.
REQ-006 i_alloc_rd  input  5  destination register of the allocated instruction.
REQ-007 i_alloc_regwrite, i_alloc_memwrite  input  1 each  instruction class flags.
REQ-008 i_alloc_store_data  input  word  store data captured at allocation (stores only).
REQ-009 o_alloc_ready  output  1  high when count < ROB_DEPTH.
REQ-010 o_alloc_tag  output  log2(ROB_DEPTH)  tag assigned to the current allocation (equals tail pointer).
REQ-011 i_complete_result  input  complete_stage_struct [0:2]  per-FU results: ROBNumber, RegWrite, MemWrite, ready, fu, FU_Result.
REQ-012 o_rf_we  output  1 [0:1]  register-file write enables, one per retire slot.
REQ-013 o_rf_waddr  output  5 [0:1]; o_rf_wdata  output  word [0:1]  retire-slot register writes.
REQ-014 o_mem_we  output  1; o_mem_addr, o_mem_wdata  output  word  committed store.
REQ-015 o_retire_count  output  2  entries retired this cycle; o_empty, o_full  output  1  occupancy flags.

Function
REQ-016 Allocation SHALL occur on an edge where i_alloc_valid && o_alloc_ready; entry written with rd, flags, store data, done=0; tail increments modulo ROB_DEPTH.
REQ-017 o_alloc_ready SHALL derive from registered count only; allocation at count==ROB_DEPTH is dropped even if a retire occurs in the same cycle.
REQ-018 A complete slot SHALL be accepted only when ready===1; ready of 0 or X is ignored with no state change.
REQ-019 Accepted result SHALL set done=1 and store FU_Result in entry ROBNumber; results targeting a non-allocated entry are ignored.
REQ-020 All three complete slots SHALL be accepted in the same cycle; two slots naming the same tag resolve to the higher slot index.
REQ-021 Retire window = up to RETIRE_WIDTH consecutive entries from head; slot 0 retires if head allocated and done; slot 1 retires only if slot 0 retires and head+1 allocated and done.
REQ-022 At most one store SHALL retire per cycle; a store in slot 1 is held if slot 0 is also a store.
REQ-023 Entry done at edge k SHALL NOT retire before edge k+1; retire outputs are registered and valid the cycle after the retiring edge.
REQ-024 Retiring entry with RegWrite and rd != 0 drives o_rf_we=1, o_rf_waddr=rd, o_rf_wdata=result; rd==0 retires with o_rf_we=0.
REQ-025 Retiring store drives o_mem_we=1, o_mem_addr=result, o_mem_wdata=captured store data.
REQ-026 Non-retiring cycles SHALL drive all write enables to 0; data/address outputs hold prior value.
REQ-027 Head, tail and count update simultaneously; alloc plus retire in one cycle changes count by 1 - retired; pointers wrap ROB_DEPTH-1 -> 0.
REQ-028 o_empty = (count==0), o_full = (count==ROB_DEPTH), both from registered count.

Reset
REQ-029 i_rst SHALL asynchronously clear head, tail, count, all valid/done bits, o_rf_we, o_mem_we, o_retire_count; o_empty=1, o_full=0, o_alloc_ready=1.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; completions arriving during reset are dropped.
REQ-031 First allocation after reset release SHALL receive tag 0.

Structure
REQ-032 Types package SHALL hold word, complete_stage_struct, rob_tag_t, ROB_DEPTH and RETIRE_WIDTH constants.
REQ-033 One sub-module, retire_select, SHALL compute the combinational retire window from head, valid, done and store flags.

Verification
REQ-034 Allocate 3 entries (tags 0,1,2), complete tag 1 then tag 0 -> retire_count=2 (tags 0,1) the cycle after tag 0 completes, tag 2 remains.
REQ-035 Fill 16 entries -> o_full=1, o_alloc_ready=0; a 17th alloc is dropped; retiring head restores o_alloc_ready next cycle.
REQ-036 Complete slot with ready=X and ROBNumber=3 -> entry 3 stays not-done, no retire.
REQ-037 Head two entries both stores, both done -> store 0 retires alone, store 1 next cycle; o_mem_addr equals each FU_Result.
REQ-038 Wrap: head=15, tail=1, entries 15 and 0 done -> both retire in one cycle, head becomes 1.
REQ-039 Assert i_rst with 5 entries pending -> outputs cleared immediately, o_empty=1, next allocation tag 0.
